pu_operand_feeder: RTL and testbench
====================================

// Module: pu_operand_feeder
// PURPOSE
//  Initiator side of the PU matrix-vector interface. Holds vector x and matrix columns in a local
//  register bank, loaded by the host. On command it pulses PU start and streams one A element plus
//  one packed B column per cycle. It waits for PU done and captures the packed result. It then
//  drains the result to the host one row per valid/ready beat.
// PARAMETERS
//  WIDTH_OP1     16   width of vector element A
//  WIDTH_OP2     16   width of each matrix element in B
//  WIDTH_OUT     32   width of each result row
//  MATRIX_ROW     8   rows per column = results per run
//  MATRIX_COL    16   columns = A/B beats per run
//  DONE_TIMEOUT  64   max cycles in WAIT before error
// PORTS
//  CLK        in   1                      clock, rising edge
//  RST        in   1                      synchronous, active-high reset
//  WR_EN      in   1                      host write strobe for operand bank
//  WR_ADDR    in   $clog2(MATRIX_COL)     column index
//  WR_A       in   WIDTH_OP1              vector element for WR_ADDR
//  WR_B       in   WIDTH_OP2*MATRIX_ROW   packed column for WR_ADDR; row r at [r*WIDTH_OP2 +: WIDTH_OP2]
//  CMD_START  in   1                      run request, sampled in IDLE only
//  BUSY       out  1                      high in every state except IDLE
//  ERR        out  1                      sticky timeout flag
//  PU_START   out  1                      one-cycle start pulse to PU
//  PU_A       out  WIDTH_OP1              streamed vector element
//  PU_B       out  WIDTH_OP2*MATRIX_ROW   streamed packed column
//  PU_DONE    in   1                      PU completion, level
//  PU_OUT     in   WIDTH_OUT*MATRIX_ROW   packed PU result; row r at [r*WIDTH_OUT +: WIDTH_OUT]
//  RES_VALID  out  1                      result beat valid
//  RES_READY  in   1                      host accepts beat
//  RES_DATA   out  WIDTH_OUT              result row
//  RES_LAST   out  1                      marks row MATRIX_ROW-1
// BEHAVIOUR
//  - Reset: all outputs 0, FSM to IDLE, counters 0. Bank contents are not reset; they are undefined until written.
//  - Reset mid-run aborts immediately. No PU_START or RES beats are emitted afterwards.
//  - States: IDLE -> START -> FEED -> WAIT -> DRAIN -> IDLE; WAIT -> IDLE on timeout.
//  - IDLE: WR_EN writes bank[WR_ADDR]. CMD_START=1 -> START, clears ERR.
//    If WR_EN and CMD_START occur in the same cycle, the write lands first and the run uses the new data.
//  - WR_EN and CMD_START are ignored while BUSY=1.
//  - START: PU_START=1 for exactly this one cycle -> FEED.
//  - FEED: col_cnt 0..MATRIX_COL-1. Registered PU_A/PU_B = bank[col_cnt].
//    If CMD_START is sampled at cycle t, beat k appears at t+2+k.
//    After beat MATRIX_COL-1 -> WAIT, and PU_A/PU_B return to 0.
//  - PU_DONE is ignored outside WAIT.
//  - WAIT: timeout counter increments each cycle.
//    PU_DONE=1 -> capture PU_OUT into the result register -> DRAIN.
//    If count reaches DONE_TIMEOUT without PU_DONE -> ERR=1 and go to IDLE, with no drain.
//    If PU_DONE and the final timeout cycle coincide, PU_DONE wins.
//  - DRAIN: RES_VALID=1 starting the cycle after capture. RES_DATA = row row_idx, starting at row 0.
//    RES_LAST=1 when row_idx = MATRIX_ROW-1.
//    RES_DATA and RES_LAST hold stable while RES_VALID & ~RES_READY.
//    On a handshake, row_idx increments. The last handshake drops RES_VALID the next cycle and goes to IDLE.
//  - ERR stays 1 until RST or the next accepted CMD_START.
//  - Widths: col_cnt has $clog2(MATRIX_COL)+1 bits, row_idx has $clog2(MATRIX_ROW)+1 bits,
//    the timeout counter has $clog2(DONE_TIMEOUT+1) bits. No counter wraps in legal operation.
// STRUCTURE
//  - Shared package pu_pkg: FSM state encoding (IDLE..DRAIN) and localparams for the counter widths.
//    The PU and this block share these localparams.
//  - Sub-module pu_result_drain: captures packed PU_OUT and shifts it out with valid/ready/last.
//    The top level keeps the bank, the FSM, feed and timeout.
// TESTING
//  - Basic run: load bank[k]=A:k+1, every B row = 1. Drive CMD_START at t.
//    Expect PU_START at t+1, PU_A=1..16 at t+2..t+17, then BUSY high until drain ends.
//  - Capture/drain: PU model raises PU_DONE 3 cycles into WAIT with row r = 100+r, RES_READY=1.
//    Expect 8 beats 100..107 on consecutive cycles, RES_LAST only on 107, BUSY=0 after.
//  - Backpressure: toggle RES_READY 1,0,0,1... -> no row lost or duplicated, data stable while stalled.
//  - Timeout: PU_DONE never rises -> ERR=1 after 64 WAIT cycles, FSM IDLE, no RES_VALID.
//    Next CMD_START clears ERR.
//  - Ignore rules: WR_EN to addr 0 with value 0xFFFF during FEED leaves the bank unchanged.
//    CMD_START during DRAIN causes no extra PU_START.
//  - Reset mid-FEED at beat 5: next cycle all outputs 0. A new CMD_START restarts cleanly from beat 0.

Source files
------------

// File: rtl/pu_pkg.sv
// Shared PU interface constants: default geometry, counter widths and FSM state encoding.
// states: IDLE host may load bank | START pulse PU start | FEED stream A/B beats | WAIT await PU done | DRAIN emit result rows
package pu_pkg;

  localparam int PU_WIDTH_OP1    = 16;
  localparam int PU_WIDTH_OP2    = 16;
  localparam int PU_WIDTH_OUT    = 32;
  localparam int PU_MATRIX_ROW   = 8;
  localparam int PU_MATRIX_COL   = 16;
  localparam int PU_DONE_TIMEOUT = 64;

  localparam int PU_COL_CNT_W = $clog2(PU_MATRIX_COL) + 1;
  localparam int PU_ROW_IDX_W = $clog2(PU_MATRIX_ROW) + 1;
  localparam int PU_TMO_CNT_W = $clog2(PU_DONE_TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_FEED  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

endpackage

// File: rtl/pu_result_drain.sv
// Captures the packed PU result and shifts it out one row per valid/ready handshake.
module pu_result_drain
  import pu_pkg::*;
#(
  parameter int WIDTH_OUT  = PU_WIDTH_OUT,
  parameter int MATRIX_ROW = PU_MATRIX_ROW
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            capture_i,
  input  logic [WIDTH_OUT*MATRIX_ROW-1:0] pu_out_i,
  input  logic                            res_ready_i,
  output logic                            res_valid_o,
  output logic [WIDTH_OUT-1:0]            res_data_o,
  output logic                            res_last_o,
  output logic                            done_o
);

  localparam int ROW_IDX_W = $clog2(MATRIX_ROW) + 1;
  localparam logic [ROW_IDX_W-1:0] ROW_LAST = ROW_IDX_W'(MATRIX_ROW - 1);

  logic [WIDTH_OUT*MATRIX_ROW-1:0] res_q, res_d;
  logic [ROW_IDX_W-1:0]            row_q, row_d;
  logic                            valid_q, valid_d;
  logic                            last;
  logic                            accept;

  assign last   = valid_q && (row_q == ROW_LAST);
  assign accept = valid_q && res_ready_i;

  always_comb begin
    res_d   = res_q;
    row_d   = row_q;
    valid_d = valid_q;
    if (capture_i) begin
      res_d   = pu_out_i;
      row_d   = '0;
      valid_d = 1'b1;
    end else if (accept) begin
      // zeros shift in, so the data port reads 0 once the last row has gone
      res_d = res_q >> WIDTH_OUT;
      if (last) begin
        valid_d = 1'b0;
        row_d   = '0;
      end else begin
        row_d = row_q + ROW_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      row_q   <= row_d;
      valid_q <= valid_d;
    end
  end

  assign res_valid_o = valid_q;
  assign res_data_o  = res_q[WIDTH_OUT-1:0];
  assign res_last_o  = last;
  assign done_o      = accept && last;

endmodule

// File: rtl/pu_operand_feeder.sv
// PU initiator: host-loaded operand bank, start/feed/wait sequencing with timeout, result drain.
module pu_operand_feeder
  import pu_pkg::*;
#(
  parameter int WIDTH_OP1    = PU_WIDTH_OP1,
  parameter int WIDTH_OP2    = PU_WIDTH_OP2,
  parameter int WIDTH_OUT    = PU_WIDTH_OUT,
  parameter int MATRIX_ROW   = PU_MATRIX_ROW,
  parameter int MATRIX_COL   = PU_MATRIX_COL,
  parameter int DONE_TIMEOUT = PU_DONE_TIMEOUT
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            wr_en_i,
  input  logic [$clog2(MATRIX_COL)-1:0]   wr_addr_i,
  input  logic [WIDTH_OP1-1:0]            wr_a_i,
  input  logic [WIDTH_OP2*MATRIX_ROW-1:0] wr_b_i,
  input  logic                            cmd_start_i,
  output logic                            busy_o,
  output logic                            err_o,
  output logic                            pu_start_o,
  output logic [WIDTH_OP1-1:0]            pu_a_o,
  output logic [WIDTH_OP2*MATRIX_ROW-1:0] pu_b_o,
  input  logic                            pu_done_i,
  input  logic [WIDTH_OUT*MATRIX_ROW-1:0] pu_out_i,
  output logic                            res_valid_o,
  input  logic                            res_ready_i,
  output logic [WIDTH_OUT-1:0]            res_data_o,
  output logic                            res_last_o
);

  localparam int COL_IDX_W = $clog2(MATRIX_COL);
  localparam int COL_CNT_W = COL_IDX_W + 1;
  localparam int TMO_CNT_W = $clog2(DONE_TIMEOUT + 1);
  localparam logic [COL_CNT_W-1:0] COL_END = COL_CNT_W'(MATRIX_COL);
  localparam logic [TMO_CNT_W-1:0] TMO_END = TMO_CNT_W'(DONE_TIMEOUT);

  logic [WIDTH_OP1-1:0]            bank_a_q [MATRIX_COL];
  logic [WIDTH_OP2*MATRIX_ROW-1:0] bank_b_q [MATRIX_COL];

  logic [2:0]                      state_q, state_d;
  logic [COL_CNT_W-1:0]            col_q, col_d;
  logic [TMO_CNT_W-1:0]            tmo_q, tmo_d, tmo_inc;
  logic                            err_q, err_d;
  logic [WIDTH_OP1-1:0]            pu_a_q, pu_a_d;
  logic [WIDTH_OP2*MATRIX_ROW-1:0] pu_b_q, pu_b_d;
  logic                            capture;
  logic                            drain_done;

  // bank is data storage only, left unreset
  always_ff @(posedge clk_i) begin
    if ((state_q == ST_IDLE) && wr_en_i) begin
      bank_a_q[wr_addr_i] <= wr_a_i;
      bank_b_q[wr_addr_i] <= wr_b_i;
    end
  end

  assign tmo_inc = tmo_q + TMO_CNT_W'(1);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    pu_a_d  = '0;
    pu_b_d  = '0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start_i) begin
          state_d = ST_START;
          err_d   = 1'b0;
        end
      end
      ST_START: begin
        // beat 0 is registered during the start pulse so it lands one cycle later
        pu_a_d  = bank_a_q[0];
        pu_b_d  = bank_b_q[0];
        col_d   = COL_CNT_W'(1);
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (col_q == COL_END) begin
          col_d   = '0;
          tmo_d   = '0;
          state_d = ST_WAIT;
        end else begin
          pu_a_d = bank_a_q[col_q[COL_IDX_W-1:0]];
          pu_b_d = bank_b_q[col_q[COL_IDX_W-1:0]];
          col_d  = col_q + COL_CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (pu_done_i) begin
          capture = 1'b1;
          tmo_d   = '0;
          state_d = ST_DRAIN;
        end else if (tmo_inc == TMO_END) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      ST_DRAIN: begin
        if (drain_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      pu_a_q  <= '0;
      pu_b_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      pu_a_q  <= pu_a_d;
      pu_b_q  <= pu_b_d;
    end
  end

  pu_result_drain #(
    .WIDTH_OUT  (WIDTH_OUT),
    .MATRIX_ROW (MATRIX_ROW)
  ) u_drain (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .capture_i   (capture),
    .pu_out_i    (pu_out_i),
    .res_ready_i (res_ready_i),
    .res_valid_o (res_valid_o),
    .res_data_o  (res_data_o),
    .res_last_o  (res_last_o),
    .done_o      (drain_done)
  );

  assign busy_o     = (state_q != ST_IDLE);
  assign err_o      = err_q;
  assign pu_start_o = (state_q == ST_START);
  assign pu_a_o     = pu_a_q;
  assign pu_b_o     = pu_b_q;

endmodule

// File: tb/tb_pu_operand_feeder.sv
// Directed bench for pu_operand_feeder: feed timing, capture/drain, backpressure, timeout, ignore rules, reset.
module tb_pu_operand_feeder;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [3:0]   wr_addr;
  logic [15:0]  wr_a;
  logic [127:0] wr_b;
  logic         cmd_start;
  logic         busy;
  logic         err;
  logic         pu_start;
  logic [15:0]  pu_a;
  logic [127:0] pu_b;
  logic         pu_done;
  logic [255:0] pu_out;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_data;
  logic         res_last;

  int n_chk  = 0;
  int n_pass = 0;

  logic [127:0] ones_b;
  logic         pat [4];
  int           exp_row;

  pu_operand_feeder dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_a_i      (wr_a),
    .wr_b_i      (wr_b),
    .cmd_start_i (cmd_start),
    .busy_o      (busy),
    .err_o       (err),
    .pu_start_o  (pu_start),
    .pu_a_o      (pu_a),
    .pu_b_o      (pu_b),
    .pu_done_i   (pu_done),
    .pu_out_i    (pu_out),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_data_o  (res_data),
    .res_last_o  (res_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_pu_out(input int base);
    pu_out = '0;
    for (int r = 0; r < 8; r++) pu_out[r*32 +: 32] = 32'(base + r);
  endtask

  // issues CMD_START now, checks the start pulse and all 16 beats, returns in WAIT cycle 1
  task automatic run_to_wait(input logic [15:0] a0);
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    wr_en     = 1'b0;
    chk("start_pulse", pu_start, 1);
    chk("start_busy", busy, 1);
    chk("start_err_clear", err, 0);
    chk("start_a_idle", pu_a, 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("feed_a", pu_a, (k == 0) ? a0 : 16'(k + 1));
      chk("feed_b", pu_b, ones_b);
      chk("feed_no_start", pu_start, 0);
      chk("feed_no_valid", res_valid, 0);
      pu_done = (k == 3);
      wr_en   = (k == 5);
      wr_addr = 4'd0;
      wr_a    = 16'hFFFF;
    end
    tick();
    pu_done = 1'b0;
    wr_en   = 1'b0;
    chk("wait_a_zero", pu_a, 0);
    chk("wait_b_zero", pu_b, 0);
    chk("wait_busy", busy, 1);
    chk("wait_no_valid", res_valid, 0);
  endtask

  // caller has pu_done=1 and pu_out set; drains 8 rows with ready held high
  task automatic drain_all(input int base);
    tick();
    pu_done   = 1'b0;
    res_ready = 1'b1;
    chk("drain_err", err, 0);
    for (int r = 0; r < 8; r++) begin
      chk("drain_valid", res_valid, 1);
      chk("drain_data", res_data, 32'(base + r));
      chk("drain_last", res_last, (r == 7));
      chk("drain_no_start", pu_start, 0);
      chk("drain_busy", busy, 1);
      cmd_start = (r == 2);
      tick();
    end
    cmd_start = 1'b0;
    chk("drain_end_valid", res_valid, 0);
    chk("drain_end_busy", busy, 0);
    chk("drain_end_start", pu_start, 0);
  endtask

  initial begin
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_a      = '0;
    wr_b      = '0;
    cmd_start = 1'b0;
    pu_done   = 1'b0;
    pu_out    = '0;
    res_ready = 1'b0;
    ones_b    = {8{16'h0001}};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_start", pu_start, 0);
    chk("rst_a", pu_a, 0);
    chk("rst_b", pu_b, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_last", res_last, 0);

    for (int k = 0; k < 16; k++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(k);
      wr_a    = 16'(k + 1);
      wr_b    = ones_b;
      tick();
    end
    wr_en = 1'b0;

    // basic run, PU done 3 cycles into WAIT
    run_to_wait(16'd1);
    tick();
    tick();
    set_pu_out(100);
    pu_done = 1'b1;
    drain_all(100);

    // backpressure with ready pattern 1,0,0,1
    run_to_wait(16'd1);
    set_pu_out(200);
    pu_done = 1'b1;
    tick();
    pu_done = 1'b0;
    exp_row = 0;
    for (int c = 0; c < 40 && exp_row < 8; c++) begin
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 32'(200 + exp_row));
      chk("bp_last", res_last, (exp_row == 7));
      res_ready = pat[c % 4];
      tick();
      if (pat[c % 4]) exp_row++;
    end
    res_ready = 1'b0;
    chk("bp_rows", 32'(exp_row), 8);
    chk("bp_end_valid", res_valid, 0);
    chk("bp_end_busy", busy, 0);

    // timeout
    run_to_wait(16'd1);
    repeat (63) tick();
    chk("tmo_busy_last", busy, 1);
    chk("tmo_err_early", err, 0);
    tick();
    chk("tmo_err", err, 1);
    chk("tmo_idle", busy, 0);
    chk("tmo_no_valid", res_valid, 0);
    tick();
    tick();
    chk("tmo_err_sticky", err, 1);
    chk("tmo_no_valid2", res_valid, 0);

    // next command clears ERR
    run_to_wait(16'd1);
    set_pu_out(300);
    pu_done = 1'b1;
    drain_all(300);

    // reset during FEED at beat 5
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    repeat (6) tick();
    chk("mid_beat5", pu_a, 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_a", pu_a, 0);
    chk("mid_rst_b", pu_b, 0);
    chk("mid_rst_start", pu_start, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_err", err, 0);
    tick();
    chk("mid_rst_idle", busy, 0);
    chk("mid_rst_start2", pu_start, 0);

    // restart with a same-cycle write to column 0; PU done on the final timeout cycle
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_a    = 16'h0055;
    wr_b    = ones_b;
    run_to_wait(16'h0055);
    repeat (63) tick();
    chk("coin_busy", busy, 1);
    chk("coin_err", err, 0);
    set_pu_out(400);
    pu_done = 1'b1;
    drain_all(400);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
